// File: rtl/wb_stage.sv
// Write-back stage: selects ALU/load result, drives the ID register-file write port,
// keeps a forwarding copy of the last write, counts retired instructions and detects HALT.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | normal operation: instructions retire, write back and count
// ST_HALT | HALT retired; inputs ignored, no writes, counters frozen

module wb_stage #(
    parameter int ADDR_W = 5,
    parameter int D_W    = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_f_mem,
    input  logic [5:0]        opcode_f_mem,
    input  logic [D_W-1:0]    alu_result_f_mem,
    input  logic [D_W-1:0]    mem_data_f_mem,
    input  logic [ADDR_W-1:0] rd_add_f_mem,
    input  logic              mem_read_f_mem,
    input  logic              mem_to_reg_f_mem,
    output logic              w_2_id,
    output logic [ADDR_W-1:0] addr_2_id,
    output logic [D_W-1:0]    write_data_2_id,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [D_W-1:0]    fwd_data,
    output logic [CNT_W-1:0]  arith_cnt,
    output logic [CNT_W-1:0]  logic_cnt,
    output logic [CNT_W-1:0]  mem_cnt,
    output logic [CNT_W-1:0]  ctrl_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              halted,
    output logic              illegal_op
);

    localparam logic [5:0] OP_LOGIC_LO = 6'h06;
    localparam logic [5:0] OP_MEM_LO   = 6'h0C;
    localparam logic [5:0] OP_LDW      = 6'h0C;
    localparam logic [5:0] OP_CTRL_LO  = 6'h0E;
    localparam logic [5:0] OP_HALT     = 6'h11;
    localparam logic [5:0] OP_ILL_LO   = 6'h12;
    localparam logic [5:0] OP_ILL_HI   = 6'h3E;
    localparam logic [5:0] OP_NOP      = 6'h3F;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              w_q, w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [D_W-1:0]    data_q, data_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
    logic [D_W-1:0]    fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0]  arith_q, arith_d;
    logic [CNT_W-1:0]  logic_q, logic_d;
    logic [CNT_W-1:0]  mem_q, mem_d;
    logic [CNT_W-1:0]  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              illegal_q, illegal_d;

    logic           run;
    logic           retire;
    logic           do_write;
    logic           is_arith, is_logic, is_mem, is_ctrl, is_illegal;
    logic [D_W-1:0] wdata_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        run        = (state_q == ST_RUN);
        retire     = valid_f_mem && run && (opcode_f_mem != OP_NOP);
        is_arith   = (opcode_f_mem < OP_LOGIC_LO);
        is_logic   = (opcode_f_mem >= OP_LOGIC_LO) && (opcode_f_mem < OP_MEM_LO);
        is_mem     = (opcode_f_mem >= OP_MEM_LO) && (opcode_f_mem < OP_CTRL_LO);
        is_ctrl    = (opcode_f_mem >= OP_CTRL_LO) && (opcode_f_mem <= OP_HALT);
        is_illegal = (opcode_f_mem >= OP_ILL_LO) && (opcode_f_mem <= OP_ILL_HI);
        // Stores, control ops and r0 destinations never reach the register file.
        do_write   = retire && mem_to_reg_f_mem && (rd_add_f_mem != '0)
                     && (opcode_f_mem <= OP_LDW);
        wdata_sel  = mem_read_f_mem ? mem_data_f_mem : alu_result_f_mem;
    end

    always_comb begin
        state_d     = state_q;
        w_d         = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        arith_d     = arith_q;
        logic_d     = logic_q;
        mem_d       = mem_q;
        ctrl_d      = ctrl_q;
        total_d     = total_q;
        illegal_d   = illegal_q;

        case (state_q)
            ST_RUN: begin
                if (do_write) begin
                    w_d         = 1'b1;
                    addr_d      = rd_add_f_mem;
                    data_d      = wdata_sel;
                    fwd_valid_d = 1'b1;
                    fwd_addr_d  = rd_add_f_mem;
                    fwd_data_d  = wdata_sel;
                end
                if (retire) begin
                    if (is_arith) arith_d = sat_inc(arith_q);
                    if (is_logic) logic_d = sat_inc(logic_q);
                    if (is_mem)   mem_d   = sat_inc(mem_q);
                    if (is_ctrl)  ctrl_d  = sat_inc(ctrl_q);
                    if (is_arith || is_logic || is_mem || is_ctrl)
                        total_d = sat_inc(total_q);
                    if (is_illegal)
                        illegal_d = 1'b1;
                    if (opcode_f_mem == OP_HALT)
                        state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            w_q         <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            arith_q     <= '0;
            logic_q     <= '0;
            mem_q       <= '0;
            ctrl_q      <= '0;
            total_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            arith_q     <= arith_d;
            logic_q     <= logic_d;
            mem_q       <= mem_d;
            ctrl_q      <= ctrl_d;
            total_q     <= total_d;
            illegal_q   <= illegal_d;
        end
    end

    assign w_2_id          = w_q;
    assign addr_2_id       = addr_q;
    assign write_data_2_id = data_q;
    assign fwd_valid       = fwd_valid_q;
    assign fwd_addr        = fwd_addr_q;
    assign fwd_data        = fwd_data_q;
    assign arith_cnt       = arith_q;
    assign logic_cnt       = logic_q;
    assign mem_cnt         = mem_q;
    assign ctrl_cnt        = ctrl_q;
    assign total_cnt       = total_q;
    assign halted          = (state_q == ST_HALT);
    assign illegal_op      = illegal_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage: a driver pushes reference-model predictions,
// a monitor pops one per cycle and compares every output.

module tb_wb_stage;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_f_mem = 1'b0;
    logic [5:0]    opcode_f_mem = 6'h3F;
    logic [DW-1:0] alu_result_f_mem = '0;
    logic [DW-1:0] mem_data_f_mem = '0;
    logic [AW-1:0] rd_add_f_mem = '0;
    logic          mem_read_f_mem = 1'b0;
    logic          mem_to_reg_f_mem = 1'b0;

    logic          w_2_id;
    logic [AW-1:0] addr_2_id;
    logic [DW-1:0] write_data_2_id;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] arith_cnt, logic_cnt, mem_cnt, ctrl_cnt, total_cnt;
    logic          halted;
    logic          illegal_op;

    always #5 clk = ~clk;

    wb_stage #(.ADDR_W(AW), .D_W(DW), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_f_mem      (valid_f_mem),
        .opcode_f_mem     (opcode_f_mem),
        .alu_result_f_mem (alu_result_f_mem),
        .mem_data_f_mem   (mem_data_f_mem),
        .rd_add_f_mem     (rd_add_f_mem),
        .mem_read_f_mem   (mem_read_f_mem),
        .mem_to_reg_f_mem (mem_to_reg_f_mem),
        .w_2_id           (w_2_id),
        .addr_2_id        (addr_2_id),
        .write_data_2_id  (write_data_2_id),
        .fwd_valid        (fwd_valid),
        .fwd_addr         (fwd_addr),
        .fwd_data         (fwd_data),
        .arith_cnt        (arith_cnt),
        .logic_cnt        (logic_cnt),
        .mem_cnt          (mem_cnt),
        .ctrl_cnt         (ctrl_cnt),
        .total_cnt        (total_cnt),
        .halted           (halted),
        .illegal_op       (illegal_op)
    );

    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          fv;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
        logic [CW-1:0] c_arith;
        logic [CW-1:0] c_logic;
        logic [CW-1:0] c_mem;
        logic [CW-1:0] c_ctrl;
        logic [CW-1:0] c_total;
        logic          hlt;
        logic          ill;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("w_2_id", 64'(w_2_id), 64'(e.w));
        check("addr_2_id", 64'(addr_2_id), 64'(e.addr));
        check("write_data_2_id", 64'(write_data_2_id), 64'(e.data));
        check("fwd_valid", 64'(fwd_valid), 64'(e.fv));
        check("fwd_addr", 64'(fwd_addr), 64'(e.fa));
        check("fwd_data", 64'(fwd_data), 64'(e.fd));
        check("arith_cnt", 64'(arith_cnt), 64'(e.c_arith));
        check("logic_cnt", 64'(logic_cnt), 64'(e.c_logic));
        check("mem_cnt", 64'(mem_cnt), 64'(e.c_mem));
        check("ctrl_cnt", 64'(ctrl_cnt), 64'(e.c_ctrl));
        check("total_cnt", 64'(total_cnt), 64'(e.c_total));
        check("halted", 64'(halted), 64'(e.hlt));
        check("illegal_op", 64'(illegal_op), 64'(e.ill));
    endtask

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] c);
        int v;
        v = int'(c) + 1;
        if (v > (1 << CW) - 1) v = (1 << CW) - 1;
        return CW'(v);
    endfunction

    // Reference model: one instruction per call, outcome predicted from the ISA rules.
    task automatic model_step();
        logic retire;
        int   op;
        op     = int'(opcode_f_mem);
        retire = valid_f_mem && !m.hlt && (op != 63);
        m.w    = 1'b0;
        if (retire && op >= 18 && op <= 62) m.ill = 1'b1;
        if (retire && mem_to_reg_f_mem && rd_add_f_mem != 0 && op <= 12) begin
            m.w    = 1'b1;
            m.addr = rd_add_f_mem;
            m.data = mem_read_f_mem ? mem_data_f_mem : alu_result_f_mem;
            m.fv   = 1'b1;
            m.fa   = m.addr;
            m.fd   = m.data;
        end
        if (retire && op <= 17) begin
            if (op <= 5)       m.c_arith = bump(m.c_arith);
            else if (op <= 11) m.c_logic = bump(m.c_logic);
            else if (op <= 13) m.c_mem   = bump(m.c_mem);
            else               m.c_ctrl  = bump(m.c_ctrl);
            m.c_total = bump(m.c_total);
        end
        if (retire && op == 17) m.hlt = 1'b1;
        sb.push_back(m);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [DW-1:0] alu,
                         input logic [DW-1:0] md, input logic [AW-1:0] rd,
                         input logic mr, input logic m2r);
        @(negedge clk);
        valid_f_mem      = v;
        opcode_f_mem     = op;
        alu_result_f_mem = alu;
        mem_data_f_mem   = md;
        rd_add_f_mem     = rd;
        mem_read_f_mem   = mr;
        mem_to_reg_f_mem = m2r;
        model_step();
    endtask

    task automatic idle();
        drive(1'b0, 6'h3F, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    // Reset asserted with a writing ADD on the inputs; outputs must clear at once.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        valid_f_mem      = 1'b1;
        opcode_f_mem     = 6'h00;
        alu_result_f_mem = 32'hA5A5_0001;
        rd_add_f_mem     = 5'd6;
        mem_read_f_mem   = 1'b0;
        mem_to_reg_f_mem = 1'b1;
        #1 reset = 1'b0;
        #1 check_all('0);
        m = '0;
        sb.push_back(m);
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            sb.push_back(m);
        end
        @(negedge clk);
        reset       = 1'b1;
        valid_f_mem = 1'b0;
        model_step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_all(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int            sel;
        logic [5:0]    op;
        logic [AW-1:0] rd;
        m = '0;

        do_reset(2);
        drive(1'b1, 6'h00, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b1);
        drive(1'b1, 6'h0C, 32'h40, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
        drive(1'b1, 6'h01, 32'h99, 32'h0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 6'h3F, 32'h77, 32'h0, 5'd8, 1'b0, 1'b1);
        drive(1'b1, 6'h0D, 32'h80, 32'h0, 5'd9, 1'b0, 1'b1);
        idle();

        do_reset(2);
        idle();
        drive(1'b1, 6'h11, 32'h10, 32'h0, 5'd4, 1'b0, 1'b1);
        drive(1'b1, 6'h00, 32'h3333, 32'h0, 5'd3, 1'b0, 1'b1);
        drive(1'b1, 6'h20, 32'h1, 32'h0, 5'd2, 1'b0, 1'b1);
        idle();

        do_reset(1);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 6'h08, 32'(i), 32'h0, 5'd9, 1'b0, 1'b1);
        drive(1'b1, 6'h20, 32'hBAD, 32'h0, 5'd2, 1'b0, 1'b1);
        idle();
        idle();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                sel = int'($urandom_range(0, 15));
                if (sel <= 11)      op = 6'($urandom_range(0, 16));
                else if (sel == 12) op = 6'h11;
                else if (sel == 13) op = 6'h3F;
                else if (sel == 14) op = 6'($urandom_range(18, 62));
                else                op = 6'($urandom_range(0, 17));
                rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                drive($urandom_range(0, 3) != 0, op, $urandom, $urandom, rd,
                      1'($urandom), $urandom_range(0, 4) != 0);
            end
        end
        idle();
        idle();

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
